// File: rtl/mem_sync_sp_banked_pkg.sv
// mem_sync_pkg: SRAM macro geometry and init-sequencer states shared by the banked memory.
package mem_sync_pkg;
    localparam int MACRO_DEPTH = 1024;
    localparam int MACRO_AW = 10;
    localparam int MACRO_DW = 8;
    typedef enum logic [1:0] {ST_RST, ST_INIT, ST_READY} mem_init_state_e;
endpackage

// File: rtl/mem_sync_sp_banked_if.sv
// mem_sync_sp_banked_if: request/response bus of the banked single-port memory.
interface mem_sync_sp_banked_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = DATA_WIDTH / 8
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic [DATA_BYTES-1:0] i_wen;
    logic                  o_rsp_valid;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_init_done;
    modport master (
        output i_req_valid, i_addr, i_wdata, i_wen,
        input  o_req_ready, o_rsp_valid, o_rdata, o_init_done
    );
    modport slave (
        input  i_req_valid, i_addr, i_wdata, i_wen,
        output o_req_ready, o_rsp_valid, o_rdata, o_init_done
    );
endinterface

// File: rtl/mem_sync_sp_banked_bank.sv
// mem_bank_1k: one 1024-word bank built from a column of byte-wide macros.
module mem_bank_1k
    import mem_sync_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  csb,
    input  logic [DATA_BYTES-1:0] web,
    input  logic [MACRO_AW-1:0]   a,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    for (genvar l = 0; l < DATA_BYTES; l++) begin : g_lane
        SRAM1RW1024x8 u_macro (
            .CE (clk),
            .CSB(csb),
            .WEB(web[l]),
            .OEB(1'b0),
            .A  (a),
            .I  (d[l*MACRO_DW +: MACRO_DW]),
            .O  (q[l*MACRO_DW +: MACRO_DW])
        );
    end
endmodule

// File: rtl/sram1rw1024x8.sv
// SRAM1RW1024x8: behavioural model of the 1024x8 sync-read macro (active-low CSB/WEB/OEB).
module SRAM1RW1024x8 (
    input  logic       CE,
    input  logic       CSB,
    input  logic       WEB,
    input  logic       OEB,
    input  logic [9:0] A,
    input  logic [7:0] I,
    output logic [7:0] O
);
    logic [7:0] mem [1024];
    logic [7:0] o_q;
    always_ff @(posedge CE) begin
        if (!CSB && !WEB) mem[A] <= I;
        if (!CSB && WEB) o_q <= mem[A];
    end
    assign O = OEB ? 8'h00 : o_q;
endmodule

// File: rtl/mem_sync_sp_banked.sv
// mem_sync_sp_banked: banked single-port SRAM with handshake, zero-init sweep and optional output register.
module mem_sync_sp_banked
    import mem_sync_pkg::*;
#(
    parameter int DEPTH      = 4096,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int OUT_REG    = 0,
    parameter int INIT_ZERO  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_sync_sp_banked_if.slave  bus
);
    localparam int NUM_BANKS = DEPTH / MACRO_DEPTH;
    localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    if (DEPTH < MACRO_DEPTH || DEPTH % MACRO_DEPTH != 0 || (DEPTH & (DEPTH - 1)) != 0 ||
        DATA_WIDTH % 8 != 0) begin : g_bad_cfg
        $error("mem_sync_sp_banked: DEPTH must be a power-of-two multiple of 1024 and DATA_WIDTH a multiple of 8");
    end
    mem_init_state_e       state_q, state_d;
    logic [MACRO_AW-1:0]   cnt_q;
    logic                  init, accept, rd, rd1_q;
    logic [BW-1:0]         bank, bank1_q;
    logic [DATA_BYTES-1:0] mac_web;
    logic [MACRO_AW-1:0]   mac_a;
    logic [DATA_WIDTH-1:0] mac_d;
    logic [DATA_WIDTH-1:0] dout [NUM_BANKS];
    assign init = state_q == ST_INIT;
    assign bus.o_req_ready = state_q == ST_READY;
    assign bus.o_init_done = state_q == ST_READY;
    assign accept = bus.i_req_valid && bus.o_req_ready;
    assign rd = accept && bus.i_wen == '0;
    assign bank = BW'(bus.i_addr >> MACRO_AW);
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RST) state_d = INIT_ZERO != 0 ? ST_INIT : ST_READY;
        else if (init && cnt_q == MACRO_AW'(MACRO_DEPTH - 1)) state_d = ST_READY;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            rd1_q   <= 1'b0;
            bank1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= init ? cnt_q + 1'b1 : cnt_q;
            rd1_q   <= rd;
            bank1_q <= accept ? bank : bank1_q;
        end
    end
    // The init sweep writes zero to the same word of every bank in parallel.
    assign mac_web = init ? '0 : ~bus.i_wen;
    assign mac_a   = init ? cnt_q : bus.i_addr[MACRO_AW-1:0];
    assign mac_d   = init ? '0 : bus.i_wdata;
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank_1k #(.DATA_WIDTH(DATA_WIDTH), .DATA_BYTES(DATA_BYTES)) u_bank (
            .clk(clk),
            .csb(init ? 1'b0 : !(accept && bank == BW'(b))),
            .web(mac_web),
            .a  (mac_a),
            .d  (mac_d),
            .q  (dout[b])
        );
    end
    if (OUT_REG != 0) begin : g_oreg
        logic                  rd2_q;
        logic [DATA_WIDTH-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd2_q   <= 1'b0;
                rdata_q <= '0;
            end else begin
                rd2_q   <= rd1_q;
                rdata_q <= rd1_q ? dout[bank1_q] : rdata_q;
            end
        end
        assign bus.o_rsp_valid = rd2_q;
        assign bus.o_rdata     = rdata_q;
    end else begin : g_noreg
        assign bus.o_rsp_valid = rd1_q;
        assign bus.o_rdata     = dout[bank1_q];
    end
endmodule

// File: tb/tb_mem_sync_sp_banked.sv
// tb_mem_sync_sp_banked: directed checks of latency-1 and latency-2 instances driven in lockstep.
module tb_mem_sync_sp_banked;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    int          total = 0;
    int          bad = 0;
    int          n;
    logic        seen;

    always #5 clk = ~clk;

    mem_sync_sp_banked_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DATA_BYTES(4)) b0 ();
    mem_sync_sp_banked_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DATA_BYTES(4)) b1 ();
    assign b0.i_req_valid = valid;
    assign b0.i_addr      = addr;
    assign b0.i_wdata     = wdata;
    assign b0.i_wen       = wen;
    assign b1.i_req_valid = valid;
    assign b1.i_addr      = addr;
    assign b1.i_wdata     = wdata;
    assign b1.i_wen       = wen;

    mem_sync_sp_banked #(.DEPTH(4096), .DATA_WIDTH(32), .OUT_REG(0), .INIT_ZERO(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0));
    mem_sync_sp_banked #(.DEPTH(4096), .DATA_WIDTH(32), .OUT_REG(1), .INIT_ZERO(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [11:0] a, input logic [31:0] d, input logic [3:0] w);
        valid = 1'b1; addr = a; wdata = d; wen = w;
        @(negedge clk);
        valid = 1'b0; wen = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        op(a, 32'h0, 4'h0);
        chk({tag, ".v0"}, 32'(b0.o_rsp_valid), 32'd1);
        chk({tag, ".d0"}, b0.o_rdata, exp);
        chk({tag, ".v1early"}, 32'(b1.o_rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, ".v0off"}, 32'(b0.o_rsp_valid), 32'd0);
        chk({tag, ".v1"}, 32'(b1.o_rsp_valid), 32'd1);
        chk({tag, ".d1"}, b1.o_rdata, exp);
    endtask

    task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] d, input logic [3:0] w);
        op(a, d, w);
        chk({tag, ".v0"}, 32'(b0.o_rsp_valid), 32'd0);
        chk({tag, ".v1"}, 32'(b1.o_rsp_valid), 32'd0);
    endtask

    task automatic wait_ready(output int cnt, output logic any_rsp);
        cnt = 0;
        any_rsp = 1'b0;
        while (!b0.o_req_ready && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            any_rsp |= b0.o_rsp_valid | b1.o_rsp_valid;
        end
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; addr = '0; wdata = '0; wen = '0;
        repeat (2) @(negedge clk);
        chk("rst.ready0", 32'(b0.o_req_ready), 32'd0);
        chk("rst.done0", 32'(b0.o_init_done), 32'd0);
        chk("rst.v0", 32'(b0.o_rsp_valid), 32'd0);
        chk("rst.v1", 32'(b1.o_rsp_valid), 32'd0);
        chk("rst.rdata1", b1.o_rdata, 32'h0);
        rst_n = 1'b1;
        wait_ready(n, seen);
        chk("init.cycles", 32'(n), 32'd1025);
        chk("init.ready1", 32'(b1.o_req_ready), 32'd1);
        chk("init.done0", 32'(b0.o_init_done), 32'd1);
        chk("init.done1", 32'(b1.o_init_done), 32'd1);
        chk("init.norsp", 32'(seen), 32'd0);
        rd("rd000", 12'h000, 32'h0);
        rd("rdfff", 12'hfff, 32'h0);
        wr("wr005", 12'h005, 32'hdeadbeef, 4'hf);
        wr("wrc05", 12'hc05, 32'hcafef00d, 4'hf);
        rd("rd005", 12'h005, 32'hdeadbeef);
        rd("rdc05", 12'hc05, 32'hcafef00d);
        wr("wr010a", 12'h010, 32'h11223344, 4'hf);
        wr("wr010b", 12'h010, 32'haabbccdd, 4'b0101);
        rd("rd010", 12'h010, 32'h11bb33dd);
        wr("wr405", 12'h405, 32'h55667788, 4'hf);
        // Back-to-back reads across three banks sharing one macro address.
        valid = 1'b1; wen = 4'h0; addr = 12'h005;
        @(negedge clk);
        chk("b2b.1v0", 32'(b0.o_rsp_valid), 32'd1);
        chk("b2b.1d0", b0.o_rdata, 32'hdeadbeef);
        addr = 12'hc05;
        @(negedge clk);
        chk("b2b.2v0", 32'(b0.o_rsp_valid), 32'd1);
        chk("b2b.2d0", b0.o_rdata, 32'hcafef00d);
        chk("b2b.2v1", 32'(b1.o_rsp_valid), 32'd1);
        chk("b2b.2d1", b1.o_rdata, 32'hdeadbeef);
        addr = 12'h405;
        @(negedge clk);
        valid = 1'b0;
        chk("b2b.3v0", 32'(b0.o_rsp_valid), 32'd1);
        chk("b2b.3d0", b0.o_rdata, 32'h55667788);
        chk("b2b.3v1", 32'(b1.o_rsp_valid), 32'd1);
        chk("b2b.3d1", b1.o_rdata, 32'hcafef00d);
        @(negedge clk);
        chk("b2b.4v0", 32'(b0.o_rsp_valid), 32'd0);
        chk("b2b.4v1", 32'(b1.o_rsp_valid), 32'd1);
        chk("b2b.4d1", b1.o_rdata, 32'h55667788);
        @(negedge clk);
        chk("b2b.5v1", 32'(b1.o_rsp_valid), 32'd0);
        rd("hold.rd", 12'h005, 32'hdeadbeef);
        wr("hold.wr1", 12'h005, 32'h01020304, 4'hf);
        chk("hold.d1a", b1.o_rdata, 32'hdeadbeef);
        wr("hold.wr2", 12'h800, 32'h0badf00d, 4'hf);
        chk("hold.d1b", b1.o_rdata, 32'hdeadbeef);
        rd("raw005", 12'h005, 32'h01020304);
        rd("rd800", 12'h800, 32'h0badf00d);
        // Second init interrupted at cycle 500, with requests driven that must be ignored.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; valid = 1'b1; wen = 4'h0; addr = 12'h005;
        seen = 1'b0;
        repeat (500) begin
            @(negedge clk);
            seen |= b0.o_rsp_valid | b1.o_rsp_valid;
        end
        chk("reinit.busy", 32'(b0.o_req_ready), 32'd0);
        chk("reinit.rdnorsp", 32'(seen), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; wen = 4'hf; wdata = 32'hffffffff;
        wait_ready(n, seen);
        valid = 1'b0; wen = 4'h0;
        chk("reinit.cycles", 32'(n), 32'd1025);
        chk("reinit.norsp", 32'(seen), 32'd0);
        chk("reinit.done", 32'(b1.o_init_done), 32'd1);
        rd("reinit.rd005", 12'h005, 32'h0);
        rd("reinit.rd800", 12'h800, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
